// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush, error pulses,
// write-through on full when a read is accepted in the same cycle, and an optional FWFT read port.
module sync_fifo_flex #(
    parameter int unsigned data_width = 8,
    parameter int unsigned fifo_depth = 16,
    parameter int unsigned af_thresh  = 12,
    parameter int unsigned ae_thresh  = 4,
    parameter int unsigned fwft       = 0,
    localparam int unsigned ptr_width = $clog2(fifo_depth)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  write_en,
    input  logic [data_width-1:0] data_in,
    input  logic                  read_en,
    output logic [data_width-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ptr_width:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned cnt_width = ptr_width + 1;

    logic [ptr_width:0]    write_ptr;
    logic [ptr_width:0]    read_ptr;
    logic [data_width-1:0] mem [fifo_depth];
    logic                  rd_ok;
    logic                  wr_ok;

    // Status is derived from the extra-bit pointers; the subtraction wraps naturally.
    assign count        = write_ptr - read_ptr;
    assign empty        = (count == '0);
    assign full         = (count == cnt_width'(fifo_depth));
    assign almost_full  = (count >= cnt_width'(af_thresh));
    assign almost_empty = (count <= cnt_width'(ae_thresh));

    // A read frees a slot this cycle, so a write to a full FIFO still lands.
    assign rd_ok = read_en & ~empty;
    assign wr_ok = write_en & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) write_ptr <= write_ptr + cnt_width'(1);
            if (rd_ok) read_ptr  <= read_ptr + cnt_width'(1);
            overflow  <= write_en & ~wr_ok;
            underflow <= read_en & ~rd_ok;
        end
    end

    // Storage is never cleared; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (reset && !flush && wr_ok) begin
            mem[write_ptr[ptr_width-1:0]] <= data_in;
        end
    end

    generate
        if (fwft != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[read_ptr[ptr_width-1:0]];
        end else begin : g_std
            logic [data_width-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    dout_q <= '0;
                end else if (!flush && rd_ok) begin
                    dout_q <= mem[read_ptr[ptr_width-1:0]];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
